// File: rtl/dot9_acc_ctrl_if.sv
// rtl/dot9_acc_ctrl_if.sv - control, beat, multiplier-array and result signals of dot9_acc_ctrl
interface dot9_acc_ctrl_if;
   logic          start;
   logic [7:0]    cin_num;
   logic          busy;
   logic          in_valid;
   logic [71:0]   in_data;
   logic [71:0]   in_weight;
   logic          in_ready;
   logic [71:0]   mul_data;
   logic [71:0]   mul_weight;
   logic [143:0]  mul_dot;
   logic          out_valid;
   logic [31:0]   out_data;
   logic          out_ready;

   modport slave (
      input  start, cin_num, in_valid, in_data, in_weight, mul_dot, out_ready,
      output busy, in_ready, mul_data, mul_weight, out_valid, out_data
   );

   modport master (
      output start, cin_num, in_valid, in_data, in_weight, mul_dot, out_ready,
      input  busy, in_ready, mul_data, mul_weight, out_valid, out_data
   );
endinterface

// File: rtl/dot9_acc_ctrl.sv
// rtl/dot9_acc_ctrl.sv - 9-lane int8 dot-product sequencer with per-channel 32-bit accumulation
// Optional DOT9_RELU_EN clamps negative results to zero at the output mux.
module dot9_acc_ctrl (
   input  logic           clk,
   input  logic           rst_n,
   dot9_acc_ctrl_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_ACC, S_DRAIN, S_OUT} state_t;

   state_t              r_state;
   state_t              w_next;
   logic [8:0]          r_cin;
   logic [8:0]          r_cnt;
   logic                r_s1_vld;
   logic                r_s2_vld;
   logic [71:0]         r_mul_data;
   logic [71:0]         r_mul_weight;
   logic signed [18:0]  r_psum;
   logic signed [18:0]  w_psum;
   logic signed [31:0]  r_acc;
   logic signed [31:0]  w_result;
   logic                w_in_ready;
   logic                w_busy;
   logic                w_out_valid;
   logic                w_beat;
   logic                w_last;

   assign w_beat = bus.in_valid && w_in_ready;
   assign w_last = w_beat && ((r_cnt + 9'd1) == r_cin);

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (bus.start) w_next = S_ACC;
         S_ACC:   if (w_last) w_next = S_DRAIN;
         S_DRAIN: if (!r_s1_vld && !r_s2_vld) w_next = S_OUT;
         S_OUT:   if (bus.out_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_busy      = 1'b0;
      w_in_ready  = 1'b0;
      w_out_valid = 1'b0;
      case (r_state)
         S_ACC: begin
            w_busy     = 1'b1;
            w_in_ready = (r_cnt < r_cin);
         end
         S_DRAIN: w_busy = 1'b1;
         S_OUT: begin
            w_busy      = 1'b1;
            w_out_valid = 1'b1;
         end
         default: ;
      endcase
   end

   // Adder tree over the nine signed products; 19 bits holds 9 x 16384 worst case
   always_comb begin
      logic [15:0] v_lane;
      w_psum = '0;
      for (int i = 0; i < 9; i++) begin
         v_lane = bus.mul_dot[16*i +: 16];
         w_psum = w_psum + {{3{v_lane[15]}}, v_lane};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cin        <= '0;
         r_cnt        <= '0;
         r_s1_vld     <= 1'b0;
         r_s2_vld     <= 1'b0;
         r_mul_data   <= '0;
         r_mul_weight <= '0;
         r_psum       <= '0;
         r_acc        <= '0;
      end else begin
         if (r_state == S_IDLE && bus.start) begin
            r_cin <= {(bus.cin_num == 8'd0), bus.cin_num};
            r_cnt <= '0;
            r_acc <= '0;
         end
         if (w_beat) begin
            r_mul_data   <= bus.in_data;
            r_mul_weight <= bus.in_weight;
            r_cnt        <= r_cnt + 9'd1;
         end
         r_s1_vld <= w_beat;
         r_s2_vld <= r_s1_vld;
         if (r_s1_vld) r_psum <= w_psum;
         if (r_s2_vld) r_acc <= r_acc + {{13{r_psum[18]}}, r_psum};
      end
   end

`ifdef DOT9_RELU_EN
   assign w_result = r_acc[31] ? 32'sd0 : r_acc;
`else
   assign w_result = r_acc;
`endif

   assign bus.busy       = w_busy;
   assign bus.in_ready   = w_in_ready;
   assign bus.out_valid  = w_out_valid;
   assign bus.out_data   = w_out_valid ? w_result : 32'd0;
   assign bus.mul_data   = r_mul_data;
   assign bus.mul_weight = r_mul_weight;
endmodule

// File: tb/tb_dot9_acc_ctrl.sv
// tb/tb_dot9_acc_ctrl.sv - directed and randomized checks of dot9_acc_ctrl against a sum-of-products model
module tb_dot9_acc_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   logic [71:0] bd [256];
   logic [71:0] bw [256];

   dot9_acc_ctrl_if bus ();

   dot9_acc_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] lane_mul(input logic [7:0] a, input logic [7:0] b);
      byte sa;
      byte sb;
      int  p;
      sa = a;
      sb = b;
      p  = int'(sa) * int'(sb);
      return p[15:0];
   endfunction

   // Multiplier array sitting outside the controller
   always_comb begin
      bus.mul_dot = '0;
      for (int i = 0; i < 9; i++)
         bus.mul_dot[16*i +: 16] = lane_mul(bus.mul_data[8*i +: 8], bus.mul_weight[8*i +: 8]);
   end

   function automatic int model(input int n);
      int  s;
      byte a;
      byte b;
      s = 0;
      for (int k = 0; k < n; k++)
         for (int l = 0; l < 9; l++) begin
            a = bd[k][8*l +: 8];
            b = bw[k][8*l +: 8];
            s += int'(a) * int'(b);
         end
`ifdef DOT9_RELU_EN
      if (s < 0) s = 0;
`endif
      return s;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk72(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [71:0] rnd72();
      return 72'({$urandom(), $urandom(), $urandom()});
   endfunction

   task automatic pixel(input int cin_raw, input int gap, input int hold,
                        input bit start_in_out, input bit start_at_hs, input string tag);
      int n, idx, g, guard, t_last, e;
      logic [71:0] last_d, last_w;
      bit any;
      n = (cin_raw == 0) ? 256 : cin_raw;
      e = model(n);
      bus.start   = 1'b1;
      bus.cin_num = 8'(cin_raw);
      @(negedge clk);
      bus.start   = 1'b0;
      bus.cin_num = 8'($urandom);
      chk({tag, "_busy_on"}, 32'(bus.busy), 32'd1);
      chk({tag, "_ready_on"}, 32'(bus.in_ready), 32'd1);
      idx = 0; g = 0; guard = 0; any = 1'b0; t_last = 0;
      last_d = '0; last_w = '0;
      while (idx < n && guard < 3000) begin
         if (any) chk72({tag, "_mul_data"}, bus.mul_data, last_d);
         if (g > 0) begin
            bus.in_valid = 1'b0;
            bus.in_data  = rnd72();
            g--;
         end else begin
            bus.in_valid  = 1'b1;
            bus.in_data   = bd[idx];
            bus.in_weight = bw[idx];
            if (bus.in_ready) begin
               t_last = cyc + 1;
               last_d = bd[idx];
               last_w = bw[idx];
               idx++;
               any = 1'b1;
               g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            end
         end
         @(negedge clk);
         guard++;
      end
      bus.in_valid = 1'b0;
      chk({tag, "_beats"}, 32'(idx), 32'(n));
      chk72({tag, "_mul_data_last"}, bus.mul_data, last_d);
      chk72({tag, "_mul_weight_last"}, bus.mul_weight, last_w);
      chk({tag, "_ready_drop"}, 32'(bus.in_ready), 32'd0);
      bus.out_ready = (hold == 0);
      guard = 0;
      while (!bus.out_valid && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, "_latency"}, 32'(cyc - t_last), 32'd3);
      chk({tag, "_out_data"}, bus.out_data, 32'(e));
      for (int k = 0; k < hold; k++) begin
         bus.start = start_in_out && (k == 0);
         chk({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
         chk({tag, "_hold_data"}, bus.out_data, 32'(e));
         @(negedge clk);
      end
      bus.start     = start_at_hs;
      bus.out_ready = 1'b1;
      chk({tag, "_hs_valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, "_hs_data"}, bus.out_data, 32'(e));
      @(negedge clk);
      bus.start = 1'b0;
      chk({tag, "_valid_off"}, 32'(bus.out_valid), 32'd0);
      chk({tag, "_busy_off"}, 32'(bus.busy), 32'd0);
      @(negedge clk);
      chk({tag, "_still_idle"}, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      bus.start     = 1'b0;
      bus.cin_num   = 8'd0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_weight = '0;
      bus.out_ready = 1'b1;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_data", bus.out_data, 32'd0);
      chk72("rst_mul_data", bus.mul_data, 72'd0);
      chk72("rst_mul_weight", bus.mul_weight, 72'd0);
      rst_n = 1'b1;

      bus.in_valid  = 1'b1;
      bus.in_data   = rnd72();
      bus.in_weight = rnd72();
      repeat (2) @(negedge clk);
      chk("idle_in_ready", 32'(bus.in_ready), 32'd0);
      chk72("idle_mul_data", bus.mul_data, 72'd0);
      bus.in_valid = 1'b0;

      bd[0] = {9{8'd2}};
      bw[0] = {9{8'd3}};
      pixel(1, 0, 0, 1'b0, 1'b0, "t1");

      bd[0] = {64'd0, 8'd10};   bw[0] = {64'd0, 8'hFC};
      bd[1] = {64'd0, 8'hFB};   bw[1] = {64'd0, 8'd7};
      bd[2] = {64'd0, 8'd1};    bw[2] = {64'd0, 8'd1};
      pixel(3, 2, 0, 1'b0, 1'b0, "t2");

      for (int k = 0; k < 256; k++) begin
         bd[k] = {9{8'h80}};
         bw[k] = {9{8'h80}};
      end
      pixel(0, 0, 0, 1'b0, 1'b0, "t3");

      for (int k = 0; k < 2; k++) begin
         bd[k] = rnd72();
         bw[k] = rnd72();
      end
      pixel(2, 0, 10, 1'b1, 1'b1, "t4");

      for (int k = 0; k < 4; k++) begin
         bd[k] = rnd72();
         bw[k] = rnd72();
      end
      bus.start   = 1'b1;
      bus.cin_num = 8'd4;
      @(negedge clk);
      bus.start = 1'b0;
      for (int k = 0; k < 2; k++) begin
         bus.in_valid  = 1'b1;
         bus.in_data   = bd[k];
         bus.in_weight = bw[k];
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("mr_busy", 32'(bus.busy), 32'd0);
      chk("mr_in_ready", 32'(bus.in_ready), 32'd0);
      chk("mr_out_valid", 32'(bus.out_valid), 32'd0);
      chk("mr_out_data", bus.out_data, 32'd0);
      chk72("mr_mul_data", bus.mul_data, 72'd0);
      chk72("mr_mul_weight", bus.mul_weight, 72'd0);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("mr_no_valid", 32'({bus.out_valid, bus.busy}), 32'd0);
      end
      bd[0] = {9{8'd1}};
      bw[0] = {9{8'd1}};
      pixel(1, 0, 0, 1'b0, 1'b0, "t5");

      bd[0] = {8'd127, 64'd0};
      bw[0] = {8'h80, 64'd0};
      pixel(1, 0, 0, 1'b0, 1'b0, "t6");

      for (int r = 0; r < 6; r++) begin
         int n;
         n = int'($urandom_range(1, 12));
         for (int k = 0; k < n; k++) begin
            bd[k] = rnd72();
            bw[k] = rnd72();
         end
         pixel(n, -1, int'($urandom_range(0, 3)), 1'b0, 1'b0, "rnd");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
